// File: rtl/cmp_sar_search_if.sv
// Handshake and comparator bus between the SAR search engine and its
// environment. The engine (master) drives the trial operand and the result
// signals; the environment (slave) supplies start and the comparator flags.
interface cmp_sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] probe_b;
    logic             cmp_aeb;
    logic             cmp_agb;
    logic             cmp_alb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start,
        input  cmp_aeb,
        input  cmp_agb,
        input  cmp_alb,
        output probe_b,
        output busy,
        output done,
        output result,
        output err
    );

    modport slave (
        output start,
        output cmp_aeb,
        output cmp_agb,
        output cmp_alb,
        input  probe_b,
        input  busy,
        input  done,
        input  result,
        input  err
    );
endinterface

// File: rtl/cmp_sar_search.sv
// Successive-approximation search engine that recovers the signed value on
// the A operand of an external magnitude comparator by driving its B operand
// and reading back the AEB/AGB/ALB flags, one decision per clock.
//
// The search runs on an unsigned offset code u; the comparator sees u with
// its MSB inverted, which maps the unsigned binary search onto a signed
// compare. Only probe_b is stored; u is recovered from it on the fly.
//
// Optional feature: define CMP_SEARCH_EARLY_EXIT_EN to finish as soon as the
// comparator reports equality, returning the current probe as the result.
module cmp_sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    cmp_sar_search_if.master bus
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             one_hot;
    logic             keep;
    logic [WIDTH-1:0] cur_u;
    logic [WIDTH-1:0] dec_u;
`ifdef CMP_SEARCH_EARLY_EXIT_EN
    logic             eq_exit;
`endif

    // Decide bit k from the flags and prepare the next trial code (bit k-1 set)
    always_comb begin
        one_hot = ($countones({bus.cmp_aeb, bus.cmp_agb, bus.cmp_alb}) == 1);
        keep    = one_hot && (bus.cmp_agb || bus.cmp_aeb);
`ifdef CMP_SEARCH_EARLY_EXIT_EN
        eq_exit = one_hot && bus.cmp_aeb;
`endif
        cur_u   = bus.probe_b ^ MSB_MASK;
        dec_u   = cur_u;
        for (int i = 0; i < WIDTH; i++) begin
            if (KW'(i) == k) begin
                dec_u[i] = keep;
            end else if ((k != '0) && (KW'(i) == (k - KW'(1)))) begin
                dec_u[i] = 1'b1;
            end
        end
    end

    // Search FSM with registered trial value, status and result
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            k           <= '0;
            bus.probe_b <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.result  <= '0;
            bus.err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.probe_b <= '0;
                        k           <= KW'(WIDTH - 1);
                        bus.err     <= 1'b0;
                        bus.busy    <= 1'b1;
                        state       <= PROBE;
                    end
                end
                PROBE: begin
                    bus.err <= bus.err | ~one_hot;
`ifdef CMP_SEARCH_EARLY_EXIT_EN
                    if (eq_exit) begin
                        bus.result <= bus.probe_b;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else
`endif
                    if (k != '0) begin
                        bus.probe_b <= dec_u ^ MSB_MASK;
                        k           <= k - KW'(1);
                    end else begin
                        bus.result <= dec_u ^ MSB_MASK;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
